// File: rtl/multibyte_add_seq_if.sv
// Handshake/operand bundle for multibyte_add_seq.
//   master : upstream issuer; drives start, a, b, cin; observes ready, busy, done, sum, cout.
//   slave  : the sequencer; the reverse directions.
// Optional ovf signal exists only when MBADD_OVF_EN is defined.
interface multibyte_add_seq_if #(
  parameter int unsigned NBYTES = 4
);
  localparam int unsigned W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MBADD_OVF_EN
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-byte adder controller.
// Adds two NBYTES-byte operands plus carry-in, one byte per cycle LSB first, through a single
// 8-bit adder with a carry register. Result and carry-out appear together with a one-cycle
// done pulse and are held until the next completion.
// Ports:
//   clk   : clock, all state changes on rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of multibyte_add_seq_if (start/a/b/cin in, ready/busy/done/sum/cout out)
// Optional feature: define MBADD_OVF_EN to add the registered signed-overflow output bus.ovf.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input logic                clk,
  input logic                rst_n,
  multibyte_add_seq_if.slave bus
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    work_q;
  logic            carry_q;
  logic [IdxW-1:0] idx_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
`ifdef MBADD_OVF_EN
  logic            ovf_q;
`endif

  logic [7:0]      byte_a;
  logic [7:0]      byte_b;
  logic [8:0]      add_res;
  logic [W-1:0]    work_next;
  logic            last_byte;

  // Shared eight_bit_adder datapath: byte idx of each latched operand plus the carry register.
  // work_next is the working result with the current byte merged in, so the final byte can be
  // published to sum in the same edge it is produced.
  always_comb begin
    byte_a    = '0;
    byte_b    = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (idx_q == IdxW'(i)) begin
        byte_a = a_q[i*8 +: 8];
        byte_b = b_q[i*8 +: 8];
      end
    end
    add_res   = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, carry_q};
    work_next = work_q;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (idx_q == IdxW'(i)) begin
        work_next[i*8 +: 8] = add_res[7:0];
      end
    end
    last_byte = (idx_q == IdxW'(NBYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef MBADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new request exactly like IDLE, giving one result per NBYTES+1 cycles.
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          work_q  <= work_next;
          carry_q <= add_res[8];
          if (last_byte) begin
            idx_q   <= '0;
            sum_q   <= work_next;
            cout_q  <= add_res[8];
`ifdef MBADD_OVF_EN
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (work_next[W-1] != a_q[W-1]);
`endif
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
`ifdef MBADD_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
module tb_multibyte_add_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  multibyte_add_seq_if #(.NBYTES(4)) bus4 ();
  multibyte_add_seq_if #(.NBYTES(1)) bus1 ();

  multibyte_add_seq #(.NBYTES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  multibyte_add_seq #(.NBYTES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // Issue one request to the 4-byte DUT; returns edges from accept to done and busy cycles seen.
  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output int lat, output int busy_cnt);
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = c;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    busy_cnt   = (bus4.busy === 1'b1) ? 1 : 0;
    lat        = 0;
    while (bus4.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus4.busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bus4.start = 1'($urandom);
    bus4.a     = $urandom;
    bus4.b     = $urandom;
    bus4.cin   = 1'($urandom);
    bus1.start = 1'($urandom);
    bus1.a     = 8'($urandom);
    bus1.b     = 8'($urandom);
    bus1.cin   = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus4.ready, bus4.busy, bus4.done, bus4.cout} !== 4'b1000 || bus4.sum !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_n4: rdy/busy/done/cout=%b sum=%h, required 1000 sum=00000000",
               {bus4.ready, bus4.busy, bus4.done, bus4.cout}, bus4.sum);
    end
    vectors++;
    if ({bus1.ready, bus1.busy, bus1.done, bus1.cout} !== 4'b1000 || bus1.sum !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_n1: rdy/busy/done/cout=%b sum=%h, required 1000 sum=00",
               {bus1.ready, bus1.busy, bus1.done, bus1.cout}, bus1.sum);
    end
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple;
    int lat, bc;
    issue4(32'h0000_00FF, 32'h0000_0001, 1'b0, lat, bc);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL ripple_latency: done after %0d edges, required 4", lat);
    end
    vectors++;
    if (bc !== 4) begin
      miscompares++;
      $display("FAIL ripple_busy: busy for %0d cycles, required 4", bc);
    end
    vectors++;
    if (bus4.sum !== 32'h0000_0100 || bus4.cout !== 1'b0 || bus4.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ripple_sum: sum=%h cout=%b ready=%b, required 00000100 0 1",
               bus4.sum, bus4.cout, bus4.ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus4.done !== 1'b0 || bus4.sum !== 32'h0000_0100 || bus4.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ripple_hold: done=%b sum=%h ready=%b, required 0 00000100 1",
               bus4.done, bus4.sum, bus4.ready);
    end
  endtask

  task automatic test_full_wrap;
    int lat, bc;
    issue4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat, bc);
    vectors++;
    if (lat !== 4 || bus4.sum !== 32'h0 || bus4.cout !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_ones: lat=%0d sum=%h cout=%b, required 4 00000000 1",
               lat, bus4.sum, bus4.cout);
    end
`ifdef MBADD_OVF_EN
    vectors++;
    if (bus4.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_ones_ovf: ovf=%b, required 0", bus4.ovf);
    end
`endif
    // Issued straight from the DONE cycle.
    issue4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, bc);
    vectors++;
    if (lat !== 4 || bus4.sum !== 32'h8000_0000 || bus4.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_signed: lat=%0d sum=%h cout=%b, required 4 80000000 0",
               lat, bus4.sum, bus4.cout);
    end
`ifdef MBADD_OVF_EN
    vectors++;
    if (bus4.ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_signed_ovf: ovf=%b, required 1", bus4.ovf);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_abort;
    int lat;
    bit saw_done;
    bus4.a     = 32'h1234_5678;
    bus4.b     = 32'h1111_1111;
    bus4.cin   = 1'b0;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    // New request while running must be ignored.
    bus4.a     = 32'hDEAD_BEEF;
    bus4.b     = 32'h0F0F_0F0F;
    bus4.cin   = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat        = 1;
    while (bus4.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== 4 || bus4.sum !== 32'h2345_6789 || bus4.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: lat=%0d sum=%h cout=%b, required 4 23456789 0",
               lat, bus4.sum, bus4.cout);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus4.busy !== 1'b0 || bus4.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_no_restart: busy=%b ready=%b, required 0 1", bus4.busy, bus4.ready);
    end
    // Abort: accept at edge k, reset low at edge k+2.
    bus4.a     = 32'hAAAA_AAAA;
    bus4.b     = 32'h5555_5555;
    bus4.cin   = 1'b1;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus4.sum !== 32'h0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.ready !== 1'b1)
    begin
      miscompares++;
      $display("FAIL abort_reset: sum=%h busy=%b done=%b ready=%b, required 00000000 0 0 1",
               bus4.sum, bus4.busy, bus4.done, bus4.ready);
    end
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0 || bus4.sum !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_no_done: done_seen=%b sum=%h, required 0 00000000", saw_done, bus4.sum);
    end
    issue4(32'd100, 32'd100, 1'b1, lat, saw_done);
    vectors++;
    if (lat !== 4 || bus4.sum !== 32'd201 || bus4.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_recover: lat=%0d sum=%0d cout=%b, required 4 201 0",
               lat, bus4.sum, bus4.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    bus1.a     = 8'd200;
    bus1.b     = 8'd200;
    bus1.cin   = 1'b0;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", bus1.busy, bus1.done);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus1.done !== 1'(i % 2)) begin
        miscompares++;
        $display("FAIL b2b_done_cycle%0d: done=%b, required %0d", i, bus1.done, i % 2);
      end
      if (i % 2 == 1) begin
        vectors++;
        if (bus1.sum !== 8'h90 || bus1.cout !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_sum_cycle%0d: sum=%h cout=%b, required 90 1",
                   i, bus1.sum, bus1.cout);
        end
      end
    end
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    int         bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      c   = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
      bus1.a     = a;
      bus1.b     = b;
      bus1.cin   = c;
      bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (bus1.done !== 1'b1 || bus1.sum !== exp[7:0] || bus1.cout !== exp[8]) begin
        miscompares++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep_%0d: a=%h b=%h cin=%b got done=%b sum=%h cout=%b, required 1 %h %b",
                   i, a, b, c, bus1.done, bus1.sum, bus1.cout, exp[7:0], exp[8]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus4.start  = 1'b0;
    bus4.a      = '0;
    bus4.b      = '0;
    bus4.cin    = 1'b0;
    bus1.start  = 1'b0;
    bus1.a      = '0;
    bus1.b      = '0;
    bus1.cin    = 1'b0;
    test_reset();
    test_carry_ripple();
    test_full_wrap();
    test_ignore_abort();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
